// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung subtractor: prefix depth helper,
// per-level group vector type and the prefix combine cell.
package bk_pkg;

    // Default operand width of the subtractor
    localparam int BK_WIDTH = 8;

    // Prefix tree depth for a power-of-two operand width
    function automatic int clog2w(input int w);
        return $clog2(w);
    endfunction

    // One level of group propagate or generate bits, one bit per operand position
    typedef logic [BK_WIDTH-1:0] bk_lvl_t;

    // Prefix combine of a high group (gh, ph) with the adjacent lower group (gl, pl).
    // Returns {group generate, group propagate}.
    function automatic logic [1:0] bk_cell(input logic gh, input logic ph,
                                           input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

endpackage

// File: rtl/bk_upsweep.sv
// Combinational Brent-Kung up-sweep. Built in place: after the last level,
// position i holds the group P/G of the largest aligned power-of-two span that
// ends at i, so every level's group nodes are present in grp_p/grp_g and the
// positions i = 2^k - 1 already hold the full prefix P[i:0]/G[i:0].
module bk_upsweep
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] grp_p,
    output logic [WIDTH-1:0] grp_g
);
    localparam int LOG2W = clog2w(WIDTH);

    for (genvar l = 0; l <= LOG2W; l++) begin : g_level
        logic [WIDTH-1:0] lvl_p;
        logic [WIDTH-1:0] lvl_g;

        if (l == 0) begin : g_leaf
            assign lvl_p = p;
            assign lvl_g = g;
        end else begin : g_tree
            logic [WIDTH-1:0] prv_p;
            logic [WIDTH-1:0] prv_g;

            assign prv_p = g_level[l-1].lvl_p;
            assign prv_g = g_level[l-1].lvl_g;

            // Merge two half-span groups at every node that closes a span of 2^l bits
            always_comb begin
                int lo;
                lo    = 0;
                lvl_p = prv_p;
                lvl_g = prv_g;
                for (int i = 0; i < WIDTH; i++) begin
                    lo = (i >= (1 << (l - 1))) ? i - (1 << (l - 1)) : 0;
                    if (((i + 1) % (1 << l)) == 0) begin
                        {lvl_g[i], lvl_p[i]} = bk_cell(prv_g[i], prv_p[i], prv_g[lo], prv_p[lo]);
                    end
                end
            end
        end
    end

    assign grp_p = g_level[LOG2W].lvl_p;
    assign grp_g = g_level[LOG2W].lvl_g;

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Two-stage pipelined subtractor diff = a - b - bin, computed as a + ~b + ~bin
// on a Brent-Kung prefix network. Stage 1 registers the up-sweep, stage 2
// finishes the down-sweep and registers the result and flags.
//
// Handshake: a transfer happens on a side whenever valid and ready are both
// high at a rising edge. in_ready never looks at in_valid, out_valid never
// looks at out_ready, and a presented result holds until it is taken.
module brent_kung_sub_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG2W = clog2w(WIDTH);

    // Handshake control
    logic s1_adv;
    logic s2_adv;
    logic accept;
    logic s2_load;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;

    // Stage 1 registers: bit propagate, in-place group P/G, carry-in, sign bits
    logic [WIDTH-1:0] s1_p_q,     s1_p_d;
    logic [WIDTH-1:0] s1_grp_p_q, s1_grp_p_d;
    logic [WIDTH-1:0] s1_grp_g_q, s1_grp_g_d;
    logic             s1_c0_q,    s1_c0_d;
    logic             s1_a_msb_q, s1_a_msb_d;
    logic             s1_b_msb_q, s1_b_msb_d;

    // Stage 2 registers: result and flags
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q,  ovf_d;
    logic             zero_q, zero_d;

    // Combinational datapath
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] up_grp_p;
    logic [WIDTH-1:0] up_grp_g;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_calc;

    // Subtraction as addition of the inverted subtrahend
    assign bit_p = a ^ ~b;
    assign bit_g = a & ~b;

    bk_upsweep #(
        .WIDTH (WIDTH)
    ) u_upsweep (
        .p     (bit_p),
        .g     (bit_g),
        .grp_p (up_grp_p),
        .grp_g (up_grp_g)
    );

    // Pipeline advance: a stage moves when it is empty or the stage after it moves
    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;
        accept     = in_valid & s1_adv;
        s2_load    = s2_adv & s1_valid_q;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    // Down-sweep: fill the prefix at every position that is not 2^k - 1 by
    // combining its own group with the finished prefix just below that group
    always_comb begin
        int lo;
        lo    = 0;
        pre_p = s1_grp_p_q;
        pre_g = s1_grp_g_q;
        for (int l = LOG2W - 1; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                lo = (i >= (1 << l)) ? i - (1 << l) : 0;
                if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (1 << l))) begin
                    {pre_g[i], pre_p[i]} = bk_cell(s1_grp_g_q[i], s1_grp_p_q[i], pre_g[lo], pre_p[lo]);
                end
            end
        end
        carry[0] = s1_c0_q;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i + 1] = pre_g[i] | (pre_p[i] & s1_c0_q);
        end
        diff_calc = s1_p_q ^ carry[WIDTH-1:0];
    end

    // Stage data loads only when its stage advances with a valid operation
    always_comb begin
        s1_p_d     = s1_p_q;
        s1_grp_p_d = s1_grp_p_q;
        s1_grp_g_d = s1_grp_g_q;
        s1_c0_d    = s1_c0_q;
        s1_a_msb_d = s1_a_msb_q;
        s1_b_msb_d = s1_b_msb_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (accept) begin
            s1_p_d     = bit_p;
            s1_grp_p_d = up_grp_p;
            s1_grp_g_d = up_grp_g;
            s1_c0_d    = ~bin;
            s1_a_msb_d = a[WIDTH-1];
            s1_b_msb_d = b[WIDTH-1];
        end
        if (s2_load) begin
            diff_d = diff_calc;
            bout_d = ~carry[WIDTH];
            ovf_d  = (s1_a_msb_q ^ s1_b_msb_q) & (diff_calc[WIDTH-1] ^ s1_a_msb_q);
            zero_d = (diff_calc == '0);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_grp_p_q <= '0;
            s1_grp_g_q <= '0;
            s1_c0_q    <= 1'b0;
            s1_a_msb_q <= 1'b0;
            s1_b_msb_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_p_q     <= s1_p_d;
            s1_grp_p_q <= s1_grp_p_d;
            s1_grp_g_q <= s1_grp_g_d;
            s1_c0_q    <= s1_c0_d;
            s1_a_msb_q <= s1_a_msb_d;
            s1_b_msb_q <= s1_b_msb_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Bench for brent_kung_sub_pipe: directed arithmetic and boundary cases,
// a stall/refill sequence, then randomized traffic with a mid-stream reset.
module tb_brent_kung_sub_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected results in issue order, packed as {zero, ovf, bout, diff}
    logic [W+2:0] exp_q[$];

    brent_kung_sub_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Clock and watchdog
    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer arithmetic on the operands
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic bi);
        int ud;
        int sd;
        logic [W-1:0] d;
        ud = int'(x) - int'(y) - int'(bi);
        sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
        d  = ud[W-1:0];
        return {(d == '0), (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1), (ud < 0), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive at the falling edge, sample 1 ns later,
    // score any presented result and record any accepted operation
    task automatic drive_cycle(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tbin, input logic ordy,
                               output logic acc, output logic ov, output logic [W+2:0] res);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        a         = ta;
        b         = tb;
        bin       = tbin;
        out_ready = ordy;
        #1;
        ov  = out_valid;
        res = {zero, ovf, bout, diff};
        exp_rdy = !((exp_q.size() == 2) && !ordy);
        check("in_ready", in_ready, exp_rdy);
        if (exp_q.size() == 2) check("full_out_valid", out_valid, 1'b1);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("stale_out_valid", out_valid, 1'b0);
            end else begin
                check("result", res, exp_q[0]);
                if (ordy) void'(exp_q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) exp_q.push_back(ref_sub(ta, tb, tbin));
    endtask

    // Single operation through an empty pipe, checked against a fixed answer
    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tbin, input logic [W+2:0] want);
        logic acc;
        logic ov;
        logic [W+2:0] res;
        drive_cycle(1'b1, ta, tb, tbin, 1'b1, acc, ov, res);
        check({tag, "_accept"}, acc, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check({tag, "_early"}, ov, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check({tag, "_valid"}, ov, 1'b1);
        check({tag, "_result"}, res, want);
    endtask

    initial begin
        logic         acc;
        logic         ov;
        logic [W+2:0] res;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic         rv;
        logic         rr;
        int           n_acc;
        int           cyc;
        bit           did_rst;

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_flags", {bout, ovf, zero}, 3'b000);
        check("rst_in_ready", in_ready, 1'b1);

        // Arithmetic cases; expected = {zero, ovf, bout, diff}
        directed("t1_5m3",       8'h05, 8'h03, 1'b0, 11'h002);
        directed("t2_3m5",       8'h03, 8'h05, 1'b0, 11'h1FE);
        directed("t3_80m01",     8'h80, 8'h01, 1'b0, 11'h27F);
        directed("t4_10m0f_b1",  8'h10, 8'h0F, 1'b1, 11'h400);
        directed("bnd_equal",    8'h5A, 8'h5A, 1'b0, 11'h400);
        directed("bnd_0mff_b1",  8'h00, 8'hFF, 1'b1, 11'h500);
        directed("bnd_80m7f",    8'h80, 8'h7F, 1'b0, 11'h201);

        // Stall: output blocked, four back-to-back operations offered
        n_acc = 0;
        drive_cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, acc, ov, res);
        check("stall_acc0", acc, 1'b1);
        n_acc += int'(acc);
        drive_cycle(1'b1, 8'h90, 8'h0F, 1'b1, 1'b0, acc, ov, res);
        check("stall_acc1", acc, 1'b1);
        n_acc += int'(acc);
        drive_cycle(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b0, acc, ov, res);
        check("stall_blocked0", acc, 1'b0);
        check("stall_out_valid0", ov, 1'b1);
        check("stall_head0", res, ref_sub(8'h11, 8'h22, 1'b0));
        n_acc += int'(acc);
        drive_cycle(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b0, acc, ov, res);
        check("stall_blocked1", acc, 1'b0);
        check("stall_head1", res, ref_sub(8'h11, 8'h22, 1'b0));
        n_acc += int'(acc);
        check("stall_accept_count", n_acc, 2);

        // Release: remaining operations enter, results leave one per cycle
        drive_cycle(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, acc, ov, res);
        check("release_acc2", acc, 1'b1);
        check("release_ov0", ov, 1'b1);
        drive_cycle(1'b1, 8'h00, 8'h01, 1'b1, 1'b1, acc, ov, res);
        check("release_acc3", acc, 1'b1);
        check("release_ov1", ov, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check("release_ov2", ov, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check("release_ov3", ov, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check("release_drained", ov, 1'b0);
        check("release_queue", exp_q.size(), 0);

        // Random traffic with a reset partway through
        n_acc   = 0;
        cyc     = 0;
        did_rst = 1'b0;
        while ((n_acc < 10000) && (cyc < 40000)) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (!did_rst && (n_acc >= 5000)) begin
                did_rst = 1'b1;
                @(negedge clk);
                rst       = 1'b1;
                in_valid  = 1'b1;
                a         = ra;
                b         = rb;
                bin       = rbin;
                out_ready = 1'b0;
                @(negedge clk);
                rst       = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                #1;
                check("midrst_out_valid", out_valid, 1'b0);
                check("midrst_in_ready", in_ready, 1'b1);
                exp_q.delete();
            end
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            drive_cycle(rv, ra, rb, rbin, rr, acc, ov, res);
            if (acc) n_acc++;
            cyc++;
        end
        check("random_op_count", n_acc, 10000);

        // Drain whatever is still in flight
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 20)) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
        check("idle_out_valid", ov, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
